// File: rtl/mp_add_pkg.sv
// Shared types and constants for the serial multi-precision adder.
package mp_add_pkg;

    localparam int SLICE_W        = 16;
    localparam int NSLICE_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_16bit.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups with a
// lookahead unit across the group generate/propagate terms.
module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        pg,
    output logic        gg
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  gc;

    // Bit and group generate/propagate, group carries, then in-group carries and sum.
    always_comb begin
        g = a & b;
        p = a ^ b;

        for (int k = 0; k < 4; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end

        gc[0] = cin;
        gc[1] = grp_g[0] | (grp_p[0] & cin);
        gc[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
        gc[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
              | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
        gc[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
              | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
              | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end

        sum  = p ^ c;
        cout = gc[4];
        pg   = &grp_p;
        gg   = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
    end

endmodule

// File: rtl/mp_add_seq.sv
// Serial W-bit add/subtract: one 16-bit slice per cycle through a single
// shared CLA, LSB slice first, with a valid/ready handshake on each side.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int NSLICE = NSLICE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      op_sub,
    input  logic [SLICE_W*NSLICE-1:0] a,
    input  logic [SLICE_W*NSLICE-1:0] b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SLICE_W*NSLICE-1:0] result,
    output logic                      cout,
    output logic                      ovf
);

    localparam int W     = SLICE_W * NSLICE;
    // A single-slice build still needs a one-bit counter to stay legal.
    localparam int CNT_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               sub_q, sub_d;
    logic [W-1:0]       result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] b_eff;
    logic [SLICE_W-1:0] cla_sum;
    logic               cla_cout;
    logic               cla_pg_unused;
    logic               cla_gg_unused;
    logic               last_slice;

    // Select the operand slice addressed by the counter; subtract feeds ~B.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_slice = a_q[i*SLICE_W +: SLICE_W];
                b_slice = b_q[i*SLICE_W +: SLICE_W];
            end
        end
        b_eff      = sub_q ? ~b_slice : b_slice;
        last_slice = (cnt_q == CNT_W'(NSLICE - 1));
    end

    cla_16bit u_cla (
        .a    (a_slice),
        .b    (b_eff),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout),
        .pg   (cla_pg_unused),
        .gg   (cla_gg_unused)
    );

    // Next-state logic for the FSM, operand capture and slice-by-slice result build.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = op_sub;
                    cnt_d   = '0;
                    carry_d = op_sub;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        result_d[i*SLICE_W +: SLICE_W] = cla_sum;
                    end
                end
                carry_d = cla_cout;
                if (last_slice) begin
                    cnt_d   = '0;
                    cout_d  = cla_cout;
                    ovf_d   = (a_slice[SLICE_W-1] == b_eff[SLICE_W-1])
                            && (cla_sum[SLICE_W-1] != a_slice[SLICE_W-1]);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight and clears outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Testbench for mp_add_seq: random and directed operations, scoreboard
// queue filled by the driver and drained by an independent output monitor.
module tb_mp_add_seq;

    localparam int NSLICE = 4;
    localparam int W      = 16 * NSLICE;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk;
    logic         n_rst;
    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    exp_t sb[$];
    exp_t mon_e;
    int   checks;
    int   fails;

    mp_add_seq #(.NSLICE(NSLICE)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the design wedges in a way no bounded wait catches.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d fails=%0d", checks, fails);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference arithmetic: exact signed/unsigned results, then reduce modulo 2^W.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub);
        exp_t               e;
        logic [W:0]         u;
        logic signed [W:0]  s;
        if (sub) begin
            s    = $signed({av[W-1], av}) - $signed({bv[W-1], bv});
            e.co = (av >= bv);
        end else begin
            u    = {1'b0, av} + {1'b0, bv};
            s    = $signed({av[W-1], av}) + $signed({bv[W-1], bv});
            e.co = u[W];
        end
        e.res = s[W-1:0];
        e.ov  = (s[W] != s[W-1]);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Issue one operation, scramble inputs afterwards, check latency, hold DONE, then release.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic sub, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", W'(in_ready), W'(1));
            return;
        end
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        op_sub   = sub;
        sb.push_back(model(av, bv, sub));
        @(posedge clk); #1;
        a      = {$urandom(), $urandom()};
        b      = {$urandom(), $urandom()};
        op_sub = 1'($urandom());
        n = 0;
        while (!out_valid && n < NSLICE + 10) begin
            in_valid = 1'($urandom());
            @(posedge clk); #1;
            n++;
        end
        checkOutput("latency", W'(n), W'(NSLICE));
        if (!out_valid) begin
            in_valid = 1'b0;
            void'(sb.pop_front());
            return;
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom());
            a        = {$urandom(), $urandom()};
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("idle_after_handshake", W'(in_ready), W'(1));
    endtask

    // Start an operation and pull reset while slice 2 is being computed.
    task automatic abortRun(input logic [W-1:0] av, input logic [W-1:0] bv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        op_sub   = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_rst = 1'b0;
        #1;
        checkOutput("abort_result", result, '0);
        checkOutput("abort_cout", W'(cout), '0);
        checkOutput("abort_ovf", W'(ovf), '0);
        checkOutput("abort_out_valid", W'(out_valid), '0);
        checkOutput("abort_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;
        n_rst = 1'b1;
    endtask

    // Monitor: compare every DONE cycle against the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (n_rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_output: got result %h with empty scoreboard", result);
            end else begin
                mon_e = sb[0];
                checkOutput("result", result, mon_e.res);
                checkOutput("cout", W'(cout), W'(mon_e.co));
                checkOutput("ovf", W'(ovf), W'(mon_e.ov));
                checkOutput("in_ready_in_done", W'(in_ready), '0);
                if (out_ready) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Main sequence: reset checks, directed corner cases, reset abort, random traffic.
    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        checks    = 0;
        fails     = 0;
        n_rst     = 1'b0;
        in_valid  = 1'b0;
        op_sub    = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_result", result, '0);
        checkOutput("reset_cout", W'(cout), '0);
        checkOutput("reset_ovf", W'(ovf), '0);
        n_rst = 1'b1;
        #1;
        checkOutput("reset_in_ready", W'(in_ready), W'(1));
        checkOutput("reset_out_valid", W'(out_valid), '0);

        $display("[TB] directed corner cases");
        applyStimulus(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0);
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 2);
        applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 5);
        applyStimulus(64'h0, 64'h1, 1'b1, 0);
        applyStimulus(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1);

        $display("[TB] reset during calculation");
        abortRun(64'hDEAD_BEEF_0123_4567, 64'h0F0F_F0F0_1111_2222);
        applyStimulus(64'd3, 64'd4, 1'b0, 0);

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0: rb = W'($urandom_range(0, 3));
                1: rb = ra;
                2: ra = {1'b1, {(W-1){1'b0}}} | W'($urandom_range(0, 7));
                default: ;
            endcase
            applyStimulus(ra, rb, 1'($urandom()), int'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", W'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 Parameter: NSLICE, default 4, number of 16-bit slices; operand width W = 16*NSLICE.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: n_rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  requester presents an operation.
REQ-005 Port: in_ready  output  1  block can accept an operation.
REQ-006 Port: op_sub  input  1  0 = A+B, 1 = A-B; sampled on accept.
REQ-007 Port: a  input  W  operand A; sampled on accept.
REQ-008 Port: b  input  W  operand B; sampled on accept.
REQ-009 Port: out_valid  output  1  result, cout and ovf are valid.
REQ-010 Port: out_ready  input  1  consumer takes the result.
REQ-011 Port: result  output  W  sum or difference, modulo 2^W.
REQ-012 Port: cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
REQ-013 Port: ovf  output  1  two's-complement signed overflow.

Function
REQ-014 The block SHALL compute W-bit add/subtract serially over one shared 16-bit adder, one slice per cycle, LSB slice first.
REQ-015 FSM states SHALL be IDLE, CALC and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 An accept SHALL be in_valid && in_ready at a rising edge; on accept the block SHALL capture a, b and op_sub, clear the slice counter and enter CALC.
REQ-018 Operands SHALL be held in internal registers; a, b and op_sub changes after accept SHALL have no effect.
REQ-019 For subtract, the adder B input SHALL be the bitwise inverse of the captured B slice, and the slice-0 carry-in SHALL be 1; for add, slice-0 carry-in SHALL be 0.
REQ-020 Each CALC cycle k SHALL write the adder sum into result[16k+15:16k] and register the adder carry-out as the carry-in for slice k+1.
REQ-021 The slice counter SHALL be ceil(log2(NSLICE)) bits wide; after slice NSLICE-1 the FSM SHALL enter DONE with cout equal to the final carry.
REQ-022 ovf SHALL be 1 iff A[W-1] equals effective-B[W-1] and result[W-1] differs from them; effective-B is ~B for subtract.
REQ-023 Latency SHALL be fixed: an accept at edge N causes out_valid=1 in the cycle after edge N+NSLICE.
REQ-024 In DONE, result, cout and ovf SHALL hold stable until out_ready=1 at an edge, after which the FSM SHALL return to IDLE.
REQ-025 No accept SHALL occur in the DONE exit cycle; minimum spacing between accepts is NSLICE+2 cycles.
REQ-026 out_ready in IDLE or CALC and in_valid in CALC or DONE SHALL be ignored.
REQ-027 result SHALL hold its last value in IDLE; only slice writes during CALC change it.

Reset
REQ-028 While n_rst=0, state SHALL be IDLE, the counter, carry, result, cout and ovf SHALL be 0, and in_ready SHALL be 1 once n_rst deasserts with out_valid 0.
REQ-029 Reset asserted in CALC or DONE SHALL abort the operation with no output handshake; the first accept after release SHALL behave as from power-up.

Structure
REQ-030 Package mp_add_pkg SHALL hold the state enum type, SLICE_W=16 and the default NSLICE.
REQ-031 The block SHALL instantiate exactly one cla_16bit as the datapath sub-module; its pg/gg outputs are unused.
REQ-032 Operand registers, result register, carry flop, counter and FSM SHALL live in mp_add_seq; there is no other sub-module.

Verification
REQ-033 Add, a=0x0000_0000_FFFF_FFFF, b=1 -> after 4 CALC cycles result=0x0000_0001_0000_0000, cout=0, ovf=0 (carry rippling across slices).
REQ-034 Add, a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, cout=1, ovf=0.
REQ-035 Add, a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result=0x8000_0000_0000_0000, ovf=1, cout=0.
REQ-036 Subtract, a=b=0x1234_5678_9ABC_DEF0 -> result=0, cout=1, ovf=0; subtract 0-1 -> result=all ones, cout=0.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> result, cout and ovf stable, in_ready=0; toggle a/b during CALC -> result unchanged.
REQ-038 Pulse n_rst low during CALC slice 2 -> outputs 0 and IDLE immediately; the next op 3+4 gives result=7 at the fixed latency.
